if_fetch_unit: RTL and testbench

Instruction fetch front end: the producer side of the IF/ID interface. It drives `IF_Instruction` and `IF_PC_4` into the IF/ID register and consumes `PCWrite`, `Branch`, `Jump`, `BTB_Addr` and `Jump_Addr` from the ID stage. Toward instruction memory it runs a variable-latency req/ack handshake. A small prefetch FIFO decouples memory latency from ID-stage stalls and redirects.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_fetch_unit_if.sv | 21 ++
 rtl/fetch_fifo.sv | 44 ++++
 rtl/if_fetch_unit.sv | 109 ++++++++++
 tb/tb_if_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  localparam logic [31:0] INST_NOP = 32'd0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory req/ack bus
interface if_fetch_unit_if;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ack;
  logic [31:0] IMEM_RData;

  modport master (
    output IMEM_Req,
    output IMEM_Addr,
    input  IMEM_Ack,
    input  IMEM_RData
  );

  modport slave (
    input  IMEM_Req,
    input  IMEM_Addr,
    output IMEM_Ack,
    output IMEM_RData
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO, power-of-two depth, clear beats push/pop
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end feeding the IF/ID register
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PCWrite,
  input  logic                   Branch,
  input  logic [1:0]             Jump,
  input  logic [31:0]            BTB_Addr,
  input  logic [31:0]            Jump_Addr,
  input  logic [31:0]            JR_Addr,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            IF_Instruction,
  output logic [31:0]            IF_PC_4,
  output logic                   IF_Valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drain_addr_q, drain_addr_d;
  logic [31:0]   target;
  logic          req, ack, redirect, push, pop;
  logic          fifo_empty;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count, count_next;

  assign req      = (state_q == FS_REQ) || (state_q == FS_DRAIN);
  assign ack      = req && imem.IMEM_Ack;
  assign redirect = Branch || (Jump == JMP_J) || (Jump == JMP_JR);

  always_comb begin
    target = BTB_Addr;
    if (Jump == JMP_JR)     target = JR_Addr;
    else if (Jump == JMP_J) target = Jump_Addr;
    target = word_align(target);
  end

  // A redirect squashes both the in-flight push and the ID-side pop
  assign push       = (state_q == FS_REQ) && ack && !redirect;
  assign pop        = PCWrite && !fifo_empty && !redirect;
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    if (redirect) begin
      fetch_pc_d = target;
      if (req && !ack) begin
        state_d = FS_DRAIN;
        // Keep the original address if we are already draining
        if (state_q == FS_REQ) drain_addr_d = fetch_pc_q;
      end else begin
        state_d = FS_REQ;
      end
    end else begin
      unique case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          if (push) fetch_pc_d = fetch_pc_q + 32'd4;
          state_d = (count_next < CW'(FIFO_DEPTH)) ? FS_REQ : FS_WAIT;
        end
        FS_WAIT:  if (pop) state_d = FS_REQ;
        FS_DRAIN: if (ack) state_d = FS_REQ;
        default:  state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= FS_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i ({imem.IMEM_RData, fetch_pc_q + 32'd4}),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign imem.IMEM_Req  = req;
  assign imem.IMEM_Addr = (state_q == FS_DRAIN) ? drain_addr_q : fetch_pc_q;

  assign IF_Valid       = !fifo_empty;
  assign IF_Instruction = fifo_empty ? INST_NOP : fifo_head[63:32];
  assign IF_PC_4        = fifo_empty ? 32'd0    : fifo_head[31:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized bench with queue-based fetch model
module tb_if_fetch_unit;
  localparam logic [31:0] RST_PC0 = 32'h0000_0000;
  localparam int          DEPTH0  = 2;
  localparam logic [31:0] RST_PC1 = 32'hFFFF_FFF8;
  localparam int          DEPTH1  = 4;

  logic        CLK;
  logic        d_reset, d_pcwrite, d_branch, d_ack;
  logic [1:0]  d_jump;
  logic [31:0] d_btb, d_ja, d_jr;
  logic [31:0] if_instr0, if_pc4_0, if_instr1, if_pc4_1;
  logic        if_valid0, if_valid1;

  int n_vec, n_err;

  function automatic logic [31:0] memfunc(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  if_fetch_unit_if imem0();
  if_fetch_unit_if imem1();

  assign imem0.IMEM_Ack   = d_ack;
  assign imem0.IMEM_RData = memfunc(imem0.IMEM_Addr);
  assign imem1.IMEM_Ack   = imem1.IMEM_Req;
  assign imem1.IMEM_RData = memfunc(imem1.IMEM_Addr);

  if_fetch_unit #(.RESET_PC(RST_PC0), .FIFO_DEPTH(DEPTH0)) dut0 (
    .CLK(CLK), .RESET(d_reset), .PCWrite(d_pcwrite), .Branch(d_branch),
    .Jump(d_jump), .BTB_Addr(d_btb), .Jump_Addr(d_ja), .JR_Addr(d_jr),
    .imem(imem0), .IF_Instruction(if_instr0), .IF_PC_4(if_pc4_0), .IF_Valid(if_valid0)
  );

  if_fetch_unit #(.RESET_PC(RST_PC1), .FIFO_DEPTH(DEPTH1)) dut1 (
    .CLK(CLK), .RESET(d_reset), .PCWrite(1'b1), .Branch(1'b0),
    .Jump(2'b00), .BTB_Addr(32'd0), .Jump_Addr(32'd0), .JR_Addr(32'd0),
    .imem(imem1), .IF_Instruction(if_instr1), .IF_PC_4(if_pc4_1), .IF_Valid(if_valid1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: queue of fetched {instr, pc+4}, next fetch address,
  // and the request currently presented to memory.
  logic [63:0] mq[$];
  logic [31:0] m_pc, m_req_addr;
  bit          m_req, m_stale, m_boot;

  int mem_wait, fixed_lat, max_lat;
  bit mem_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          ack, redir;
    logic [31:0] tgt;
    if (!d_reset) begin
      mq.delete();
      m_pc = RST_PC0; m_req = 0; m_req_addr = RST_PC0; m_stale = 0; m_boot = 1;
      return;
    end
    ack   = m_req && d_ack;
    redir = d_branch || d_jump == 2'b01 || d_jump == 2'b10;
    if (redir) begin
      tgt = (d_jump == 2'b10) ? d_jr : (d_jump == 2'b01) ? d_ja : d_btb;
      tgt = tgt & 32'hFFFF_FFFC;
      mq.delete();
      m_pc   = tgt;
      m_boot = 0;
      if (m_req && !ack) m_stale = 1;
      else begin m_stale = 0; m_req = 1; m_req_addr = tgt; end
      return;
    end
    if (m_boot) begin
      m_boot = 0; m_req = 1; m_req_addr = m_pc;
      return;
    end
    if (m_stale) begin
      if (ack) begin m_stale = 0; m_req = 1; m_req_addr = m_pc; end
      return;
    end
    if (d_pcwrite && mq.size() > 0) void'(mq.pop_front());
    if (ack) begin
      mq.push_back({memfunc(m_req_addr), m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
    m_req      = mq.size() < DEPTH0;
    m_req_addr = m_pc;
  endtask

  task automatic compare_all();
    chk("imem_req",  32'(imem0.IMEM_Req), 32'(m_req));
    chk("imem_addr", imem0.IMEM_Addr, m_req ? m_req_addr : m_pc);
    chk("if_valid",  32'(if_valid0), 32'(mq.size() > 0));
    chk("if_instr",  if_instr0, (mq.size() > 0) ? mq[0][63:32] : 32'd0);
    chk("if_pc4",    if_pc4_0,  (mq.size() > 0) ? mq[0][31:0]  : 32'd0);
  endtask

  task automatic drive_mem();
    if (!imem0.IMEM_Req) begin
      mem_busy = 0;
      d_ack    = 0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(max_lat, 0));
      end else if (mem_wait > 0) begin
        mem_wait--;
      end
      d_ack = (mem_wait == 0);
      if (d_ack) mem_busy = 0;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
    drive_mem();
  endtask

  task automatic do_reset();
    d_reset = 0; d_pcwrite = 0; d_branch = 0; d_jump = 2'b00;
    cycle();
    cycle();
    chk("rst_req",   32'(imem0.IMEM_Req), 32'd0);
    chk("rst_addr",  imem0.IMEM_Addr, RST_PC0);
    chk("rst_valid", 32'(if_valid0), 32'd0);
    chk("rst_instr", if_instr0, 32'd0);
    chk("rst_pc4",   if_pc4_0, 32'd0);
    d_reset = 1;
  endtask

  task automatic wait_issue(input logic [31:0] addr, input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      if (imem0.IMEM_Req && imem0.IMEM_Addr == addr && mem_busy && mem_wait == 3) found = 1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    int n;
    bit saw_stale;
    n_vec = 0; n_err = 0;
    d_reset = 0; d_pcwrite = 0; d_branch = 0; d_jump = 2'b00; d_ack = 0;
    d_btb = 0; d_ja = 0; d_jr = 0;
    mem_busy = 0; mem_wait = 0; fixed_lat = 0; max_lat = 0;
    mq.delete(); m_pc = RST_PC0; m_req = 0; m_req_addr = RST_PC0; m_stale = 0; m_boot = 1;

    // Zero-wait streaming, then a 3-cycle ID stall
    do_reset();
    d_pcwrite = 1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 1) begin
        chk("first_req", 32'(imem0.IMEM_Req), 32'd1);
        chk("first_addr", imem0.IMEM_Addr, 32'h0);
      end
      if (k == 2) begin
        chk("first_pc4", if_pc4_0, 32'h4);
        chk("first_instr", if_instr0, memfunc(32'h0));
        chk("wrap_pc4_a", if_pc4_1, 32'hFFFF_FFFC);
      end
      if (k == 3) begin
        chk("second_pc4", if_pc4_0, 32'h8);
        chk("wrap_pc4_b", if_pc4_1, 32'h0000_0000);
        chk("wrap_instr", if_instr1, memfunc(32'hFFFF_FFFC));
      end
      if (k == 4) chk("wrap_pc4_c", if_pc4_1, 32'h0000_0004);
    end
    d_pcwrite = 0;
    for (int h = 0; h < 3; h++) begin
      cycle();
      chk("hold_pc4", if_pc4_0, 32'd28);
      chk("hold_req", 32'(imem0.IMEM_Req), 32'd0);
    end
    d_pcwrite = 1;
    cycle();
    chk("resume_pc4_a", if_pc4_0, 32'd32);
    cycle();
    chk("resume_pc4_b", if_pc4_0, 32'd36);

    // Branch and jr together: jr wins
    d_branch = 1; d_btb = 32'h40; d_jump = 2'b10; d_jr = 32'h80;
    cycle();
    d_branch = 0; d_jump = 2'b00;
    chk("redir_valid", 32'(if_valid0), 32'd0);
    chk("redir_addr", imem0.IMEM_Addr, 32'h80);
    cycle();
    chk("redir_pc4", if_pc4_0, 32'h84);

    // Jump while a slow request to 0x10 is outstanding
    fixed_lat = 3;
    do_reset();
    d_pcwrite = 1;
    wait_issue(32'h10, "issue_0x10");
    d_jump = 2'b01; d_ja = 32'h100;
    n = 0;
    saw_stale = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      d_jump = 2'b00;
      n++;
      if (if_valid0 && if_pc4_0 == 32'h14) saw_stale = 1;
      if (imem0.IMEM_Req && imem0.IMEM_Addr != 32'h10) break;
    end
    chk("drain_cycles", 32'(n), 32'd4);
    chk("drain_target", imem0.IMEM_Addr, 32'h100);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (if_valid0 && if_pc4_0 == 32'h14) saw_stale = 1;
    end
    chk("stale_dropped", 32'(saw_stale), 32'd0);

    // Reset while draining
    do_reset();
    d_pcwrite = 1;
    wait_issue(32'h8, "issue_0x8");
    d_jump = 2'b01; d_ja = 32'h200;
    cycle();
    d_jump = 2'b00;
    chk("drain_req", 32'(imem0.IMEM_Req), 32'd1);
    chk("drain_addr", imem0.IMEM_Addr, 32'h8);
    d_reset = 0;
    cycle();
    chk("drst_req", 32'(imem0.IMEM_Req), 32'd0);
    chk("drst_addr", imem0.IMEM_Addr, RST_PC0);
    chk("drst_valid", 32'(if_valid0), 32'd0);
    chk("drst_pc4", if_pc4_0, 32'd0);
    d_reset = 1;
    cycle();
    chk("drst_restart_req", 32'(imem0.IMEM_Req), 32'd1);
    chk("drst_restart_addr", imem0.IMEM_Addr, RST_PC0);

    // Random traffic
    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) max_lat = (i / 500) % 4;
      d_reset   = ($urandom_range(199, 0) != 0);
      d_pcwrite = ($urandom_range(3, 0) != 0);
      if ($urandom_range(11, 0) == 0) begin
        d_branch = 1'($urandom_range(1, 0));
        d_jump   = 2'($urandom_range(3, 0));
      end else begin
        d_branch = 0;
        d_jump   = ($urandom_range(15, 0) == 0) ? 2'b11 : 2'b00;
      end
      d_btb = $urandom; d_ja = $urandom; d_jr = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
